// File: rtl/seg7_scan.sv
// seg7_scan: scans a 16-bit hex value onto the Basys3 4-digit common-anode
// seven-segment display, one digit per refresh slot. The value is latched
// once per frame so a value that changes mid-frame never shows mixed digits.
// Optional leading-zero blanking: define SEG7_SCAN_LZB_EN.
module seg7_scan #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] prescaler;
  logic [1:0]    dig;
  logic [15:0]   shadow;
  logic          tick;

  logic [3:0]    nib;
  logic          sup;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  // Hex nibble to active-low {g,f,e,d,c,b,a} cathode pattern.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick = (prescaler == PRE_LAST);

  // Free-running prescaler, digit index and frame latch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      dig       <= '0;
      shadow    <= '0;
    end else begin
      if (tick) begin
        prescaler <= '0;
        dig       <= dig + 2'd1;
        if (dig == 2'd3)
          shadow <= value;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Next-cycle anode/cathode pattern for the current digit slot.
  always_comb begin
    nib = shadow[{dig, 2'b00} +: 4];
    sup = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
    case (dig)
      2'd1:    sup = (shadow[15:4]  == 12'h000);
      2'd2:    sup = (shadow[15:8]  == 8'h00);
      2'd3:    sup = (shadow[15:12] == 4'h0);
      default: sup = 1'b0;
    endcase
`endif
    if (blank || sup) begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << dig);
      seg_d = hex7(nib);
      dp_d  = ~dp_mask[dig];
    end
  end

  // Output register: an/seg/dp change together on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= '1;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed test of seg7_scan with REFRESH_DIV=4.
// Expectations adapt to SEG7_SCAN_LZB_EN when the bench is built with it.
module tb_seg7_scan;

`ifdef SEG7_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int unsigned errors;
  int unsigned checks;

  seg7_scan #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .dp_mask (dp_mask),
    .blank   (blank),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
    check({tag, ".an"},  {12'h0, an},  {12'h0, ea});
    check({tag, ".seg"}, {9'h0, seg},  {9'h0, es});
    check({tag, ".dp"},  {15'h0, dp},  {15'h0, ed});
  endtask

  // One full 4-cycle slot; sup marks a digit suppressed by leading-zero blanking.
  task automatic check_slot(input string tag, input logic [3:0] ea, input logic [6:0] es,
                            input logic ed, input logic sup);
    for (int i = 0; i < 4; i++) begin
      step();
      if (LZB && sup) check_out(tag, 4'hF, 7'h7F, 1'b1);
      else            check_out(tag, ea, es, ed);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    value   = 16'h1234;
    dp_mask = 4'b0000;
    blank   = 1'b0;
    #1 reset = 1'b0;
    #2 check_out("reset_async", 4'hF, 7'h7F, 1'b1);
    step();
    step();
    check_out("reset_held", 4'hF, 7'h7F, 1'b1);
    @(negedge clk) reset = 1'b1;

    // 1: first frame shows the reset shadow 0000, then 1234.
    check_slot("f0s0", 4'b1110, 7'h40, 1'b1, 1'b0);
    check_slot("f0s1", 4'b1101, 7'h40, 1'b1, 1'b1);
    check_slot("f0s2", 4'b1011, 7'h40, 1'b1, 1'b1);
    check_slot("f0s3", 4'b0111, 7'h40, 1'b1, 1'b1);
    check_slot("f1s0", 4'b1110, 7'h19, 1'b1, 1'b0);
    check_slot("f1s1", 4'b1101, 7'h30, 1'b1, 1'b0);
    value = 16'hABCD;
    check_slot("f1s2", 4'b1011, 7'h24, 1'b1, 1'b0);
    check_slot("f1s3", 4'b0111, 7'h79, 1'b1, 1'b0);

    // 2: ABCD latched; change to 5678 during digit 1 is invisible this frame.
    check_slot("f2s0", 4'b1110, 7'h21, 1'b1, 1'b0);
    value = 16'h5678;
    check_slot("f2s1", 4'b1101, 7'h46, 1'b1, 1'b0);
    check_slot("f2s2", 4'b1011, 7'h03, 1'b1, 1'b0);
    check_slot("f2s3", 4'b0111, 7'h08, 1'b1, 1'b0);
    check_slot("f3s0", 4'b1110, 7'h00, 1'b1, 1'b0);
    check_slot("f3s1", 4'b1101, 7'h78, 1'b1, 1'b0);
    check_slot("f3s2", 4'b1011, 7'h02, 1'b1, 1'b0);
    value = 16'hFFFF;
    check_slot("f3s3", 4'b0111, 7'h12, 1'b1, 1'b0);
    dp_mask = 4'b0101;

    // 3: FFFF with decimal points on digits 0 and 2.
    check_slot("f4s0", 4'b1110, 7'h0E, 1'b0, 1'b0);
    check_slot("f4s1", 4'b1101, 7'h0E, 1'b1, 1'b0);
    check_slot("f4s2", 4'b1011, 7'h0E, 1'b0, 1'b0);
    check_slot("f4s3", 4'b0111, 7'h0E, 1'b1, 1'b0);

    // 4: blank for 10 cycles from the start of slot 1; scan keeps running.
    check_slot("f5s0", 4'b1110, 7'h0E, 1'b0, 1'b0);
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check_out("blank", 4'hF, 7'h7F, 1'b1);
    end
    blank = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_out("unblank_s3", 4'b0111, 7'h0E, 1'b1);
    end
    check_slot("f6s0", 4'b1110, 7'h0E, 1'b0, 1'b0);
    check_slot("f6s1", 4'b1101, 7'h0E, 1'b1, 1'b0);

    // 5: async reset in the middle of digit 2.
    step();
    check_out("f6s2", 4'b1011, 7'h0E, 1'b0);
    #2 reset = 1'b0;
    #1 check_out("reset_mid", 4'hF, 7'h7F, 1'b1);
    step();
    check_out("reset_mid_held", 4'hF, 7'h7F, 1'b1);
    @(negedge clk) reset = 1'b1;
    check_slot("r0s0", 4'b1110, 7'h40, 1'b0, 1'b0);
    check_slot("r0s1", 4'b1101, 7'h40, 1'b1, 1'b1);
    check_slot("r0s2", 4'b1011, 7'h40, 1'b0, 1'b1);
    value = 16'h0050;
    check_slot("r0s3", 4'b0111, 7'h40, 1'b1, 1'b1);

    // 6: leading zeros (suppressed only with SEG7_SCAN_LZB_EN).
    check_slot("z1s0", 4'b1110, 7'h40, 1'b0, 1'b0);
    check_slot("z1s1", 4'b1101, 7'h12, 1'b1, 1'b0);
    check_slot("z1s2", 4'b1011, 7'h40, 1'b0, 1'b1);
    value = 16'h0000;
    check_slot("z1s3", 4'b0111, 7'h40, 1'b1, 1'b1);
    check_slot("z2s0", 4'b1110, 7'h40, 1'b0, 1'b0);
    check_slot("z2s1", 4'b1101, 7'h40, 1'b1, 1'b1);
    check_slot("z2s2", 4'b1011, 7'h40, 1'b0, 1'b1);
    check_slot("z2s3", 4'b0111, 7'h40, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
